// File: rtl/ulpi_reg_ctl.sv
// ULPI register access sequencer: TX CMD, write data, STP, RX turnaround/read, with timeout and RX-cmd preemption.
// Define ULPI_REG_READ_EN to build the register read path (RTURN/RDATA); without it reads complete immediately.
module ulpi_reg_ctl #(
   parameter int unsigned NXT_TIMEOUT = 255
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       reg_en,
   input  logic       reg_we,
   input  logic [7:0] reg_addr,
   input  logic [7:0] reg_din,
   output logic       reg_rdy,
   output logic [7:0] reg_dout,
   output logic       reg_err,
   input  logic       ulpi_dir,
   input  logic       ulpi_nxt,
   input  logic [7:0] ulpi_data_in,
   output logic [7:0] ulpi_data_out,
   output logic       ulpi_stp
);

   localparam int unsigned       CNT_W    = $clog2(NXT_TIMEOUT + 1);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(NXT_TIMEOUT - 1);

   typedef enum logic [2:0] {
      IDLE,
      TXCMD,
      WDATA,
      STP,
`ifdef ULPI_REG_READ_EN
      RTURN,
      RDATA,
`endif
      WAITBUS,
      DONE
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [5:0]       addr_q, addr_d;
   logic [7:0]       din_q, din_d;
   logic             we_q, we_d;
   logic             tmo_q, tmo_d;
   logic [7:0]       data_out_q, data_out_d;
   logic             stp_q, stp_d;
   logic             rdy_q, rdy_d;
   logic             err_q, err_d;
   logic [7:0]       dout_q, dout_d;
   logic             timed_out;
   logic             counting;
`ifdef ULPI_REG_READ_EN
   logic             cap_q, cap_d;
   logic [7:0]       rd_data_q, rd_data_d;
`endif

   logic unused_bits;
`ifdef ULPI_REG_READ_EN
   assign unused_bits = ^reg_addr[7:6];
`else
   assign unused_bits = ^{reg_addr[7:6], ulpi_data_in};
`endif

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      din_d     = din_q;
      we_d      = we_q;
      tmo_d     = tmo_q;
      dout_d    = dout_q;
      timed_out = (cnt_q == CNT_LAST);
`ifdef ULPI_REG_READ_EN
      cap_d     = cap_q;
      rd_data_d = rd_data_q;
`endif

      case (state_q)
         IDLE: begin
            if (reg_en) begin
               addr_d = reg_addr[5:0];
               din_d  = reg_din;
               we_d   = reg_we;
               tmo_d  = 1'b0;
`ifdef ULPI_REG_READ_EN
               state_d = ulpi_dir ? WAITBUS : TXCMD;
`else
               // Reads are not built: complete at once with zero data, no bus activity.
               if (!reg_we) begin
                  state_d = DONE;
                  dout_d  = '0;
               end else begin
                  state_d = ulpi_dir ? WAITBUS : TXCMD;
               end
`endif
            end
         end
         TXCMD: begin
            if (ulpi_dir) begin
               state_d = WAITBUS;
            end else if (ulpi_nxt) begin
`ifdef ULPI_REG_READ_EN
               state_d = we_q ? WDATA : RTURN;
`else
               state_d = WDATA;
`endif
            end else if (timed_out) begin
               state_d = STP;
               tmo_d   = 1'b1;
            end
         end
         WDATA: begin
            if (ulpi_dir) begin
               state_d = WAITBUS;
            end else if (ulpi_nxt) begin
               state_d = STP;
            end else if (timed_out) begin
               state_d = STP;
               tmo_d   = 1'b1;
            end
         end
         STP: state_d = DONE;
`ifdef ULPI_REG_READ_EN
         RTURN: begin
            if (ulpi_dir) begin
               state_d = RDATA;
               cap_d   = 1'b0;
            end else if (timed_out) begin
               state_d = STP;
               tmo_d   = 1'b1;
            end
         end
         RDATA: begin
            // Read data is staged and only published at DONE, so a timeout leaves reg_dout intact.
            if (!cap_q) begin
               rd_data_d = ulpi_data_in;
               cap_d     = 1'b1;
            end
            if (cap_q && !ulpi_dir) begin
               state_d = DONE;
               dout_d  = rd_data_q;
            end else if (timed_out) begin
               state_d = STP;
               tmo_d   = 1'b1;
            end
         end
`endif
         WAITBUS: begin
            if (!ulpi_dir) begin
               state_d = TXCMD;
            end else if (timed_out) begin
               state_d = STP;
               tmo_d   = 1'b1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

`ifdef ULPI_REG_READ_EN
      counting = (state_q == TXCMD) || (state_q == WDATA) || (state_q == WAITBUS) ||
                 (state_q == RTURN) || (state_q == RDATA);
`else
      counting = (state_q == TXCMD) || (state_q == WDATA) || (state_q == WAITBUS);
`endif
      if (state_d != state_q || !counting) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end

      // Outputs are decoded from the next state so they line up with it once registered.
      data_out_d = '0;
      case (state_d)
         TXCMD:   data_out_d = {1'b1, ~we_d, addr_d};
         WDATA:   data_out_d = din_d;
         default: data_out_d = '0;
      endcase
      stp_d = (state_d == STP);
      rdy_d = (state_d == DONE);
      err_d = (state_d == DONE) && tmo_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         addr_q     <= '0;
         din_q      <= '0;
         we_q       <= 1'b0;
         tmo_q      <= 1'b0;
         data_out_q <= '0;
         stp_q      <= 1'b0;
         rdy_q      <= 1'b0;
         err_q      <= 1'b0;
         dout_q     <= '0;
`ifdef ULPI_REG_READ_EN
         cap_q      <= 1'b0;
         rd_data_q  <= '0;
`endif
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         addr_q     <= addr_d;
         din_q      <= din_d;
         we_q       <= we_d;
         tmo_q      <= tmo_d;
         data_out_q <= data_out_d;
         stp_q      <= stp_d;
         rdy_q      <= rdy_d;
         err_q      <= err_d;
         dout_q     <= dout_d;
`ifdef ULPI_REG_READ_EN
         cap_q      <= cap_d;
         rd_data_q  <= rd_data_d;
`endif
      end
   end

   assign ulpi_data_out = data_out_q;
   assign ulpi_stp      = stp_q;
   assign reg_rdy       = rdy_q;
   assign reg_err       = err_q;
   assign reg_dout      = dout_q;

endmodule

// File: tb/tb_ulpi_reg_ctl.sv
// Bench for ulpi_reg_ctl: per-cycle expected outputs queued at drive time and checked after each clock edge.
module tb_ulpi_reg_ctl;
   localparam int unsigned T = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       reg_en = 1'b0;
   logic       reg_we = 1'b0;
   logic [7:0] reg_addr = '0;
   logic [7:0] reg_din = '0;
   logic       reg_rdy;
   logic [7:0] reg_dout;
   logic       reg_err;
   logic       ulpi_dir = 1'b0;
   logic       ulpi_nxt = 1'b0;
   logic [7:0] ulpi_data_in = '0;
   logic [7:0] ulpi_data_out;
   logic       ulpi_stp;

   always #5 clk = ~clk;

   ulpi_reg_ctl #(.NXT_TIMEOUT(T)) dut (
      .clk(clk), .rst(rst), .reg_en(reg_en), .reg_we(reg_we), .reg_addr(reg_addr),
      .reg_din(reg_din), .reg_rdy(reg_rdy), .reg_dout(reg_dout), .reg_err(reg_err),
      .ulpi_dir(ulpi_dir), .ulpi_nxt(ulpi_nxt), .ulpi_data_in(ulpi_data_in),
      .ulpi_data_out(ulpi_data_out), .ulpi_stp(ulpi_stp)
   );

   typedef struct {
      logic [7:0] data;
      logic       stp;
      logic       rdy;
      logic       err;
      logic [7:0] dout;
      string      tag;
   } exp_t;

   typedef struct {
      logic        we;
      logic [7:0]  addr;
      logic [7:0]  din;
      int unsigned w1;    // cycles nxt held low in TXCMD
      int unsigned w2;    // cycles nxt held low in WDATA
      int unsigned dw;    // cycles dir high starting at the request
      logic        hold;  // keep reg_en asserted (with junk fields) while busy
      string       tag;
   } vec_t;

   exp_t        sb[$];
   vec_t        vecs[9];
   int unsigned total = 0;
   int unsigned bad = 0;
   logic [7:0]  exp_dout = '0;

   task automatic expect_out(input logic [7:0] data, input logic stp, input logic rdy,
                             input logic err, input string tag);
      exp_t e;
      e.data = data; e.stp = stp; e.rdy = rdy; e.err = err; e.dout = exp_dout; e.tag = tag;
      sb.push_back(e);
   endtask

   task automatic tick();
      exp_t e;
      @(posedge clk);
      #1;
      total++;
      if (sb.size() == 0) begin
         bad++;
         $display("FAIL scoreboard_empty: got no expectation for this cycle, required one");
      end else begin
         e = sb.pop_front();
         if ({ulpi_data_out, ulpi_stp, reg_rdy, reg_err, reg_dout} !== {e.data, e.stp, e.rdy, e.err, e.dout}) begin
            bad++;
            $display("FAIL %s: got data=%h stp=%b rdy=%b err=%b dout=%h, required data=%h stp=%b rdy=%b err=%b dout=%h",
                     e.tag, ulpi_data_out, ulpi_stp, reg_rdy, reg_err, reg_dout,
                     e.data, e.stp, e.rdy, e.err, e.dout);
         end
      end
   endtask

   task automatic busy(input logic hold);
      reg_en = hold;
      if (hold) begin
         reg_we   = 1'b0;
         reg_addr = 8'hFF;
         reg_din  = 8'hEE;
      end
   endtask

   task automatic run_vec(input vec_t v);
      logic [7:0] cmd;
      bit         tmo;
      tmo = 1'b0;
      cmd = {1'b1, ~v.we, v.addr[5:0]};
      reg_en = 1'b1; reg_we = v.we; reg_addr = v.addr; reg_din = v.din;
      ulpi_nxt = 1'b0; ulpi_dir = (v.dw > 0);
      if (!v.we) begin
`ifndef ULPI_REG_READ_EN
         exp_dout = 8'h00;
         expect_out(8'h00, 1'b0, 1'b1, 1'b0, {v.tag, "_rd_done"});
         tick();
         ulpi_dir = 1'b0;
         busy(v.hold);
         expect_out(8'h00, 1'b0, 1'b0, 1'b0, {v.tag, "_rd_idle"});
         tick();
         reg_en = 1'b0;
         expect_out(8'h00, 1'b0, 1'b0, 1'b0, {v.tag, "_rd_idle2"});
         tick();
`else
         reg_en = 1'b0;
         ulpi_dir = 1'b0;
`endif
         return;
      end
      if (v.dw > 0) begin
         expect_out(8'h00, 1'b0, 1'b0, 1'b0, {v.tag, "_waitbus"});
         tick();
         busy(v.hold);
         for (int unsigned i = 1; i < v.dw; i++) begin
            expect_out(8'h00, 1'b0, 1'b0, 1'b0, {v.tag, "_waitbus_hold"});
            tick();
         end
         ulpi_dir = 1'b0;
      end
      expect_out(cmd, 1'b0, 1'b0, 1'b0, {v.tag, "_txcmd"});
      tick();
      busy(v.hold);
      for (int unsigned k = 0; k < T; k++) begin
         ulpi_nxt = (k >= v.w1);
         if (ulpi_nxt) begin
            expect_out(v.din, 1'b0, 1'b0, 1'b0, {v.tag, "_wdata"});
            tick();
            break;
         end
         if (k == T - 1) begin
            tmo = 1'b1;
            expect_out(8'h00, 1'b1, 1'b0, 1'b0, {v.tag, "_stp_tmo_tx"});
         end else begin
            expect_out(cmd, 1'b0, 1'b0, 1'b0, {v.tag, "_txcmd_hold"});
         end
         tick();
      end
      if (!tmo) begin
         for (int unsigned k = 0; k < T; k++) begin
            ulpi_nxt = (k >= v.w2);
            if (ulpi_nxt) begin
               expect_out(8'h00, 1'b1, 1'b0, 1'b0, {v.tag, "_stp"});
               tick();
               break;
            end
            if (k == T - 1) begin
               tmo = 1'b1;
               expect_out(8'h00, 1'b1, 1'b0, 1'b0, {v.tag, "_stp_tmo_wd"});
            end else begin
               expect_out(v.din, 1'b0, 1'b0, 1'b0, {v.tag, "_wdata_hold"});
            end
            tick();
         end
      end
      ulpi_nxt = 1'b0;
      expect_out(8'h00, 1'b0, 1'b1, tmo, {v.tag, "_done"});
      tick();
      expect_out(8'h00, 1'b0, 1'b0, 1'b0, {v.tag, "_idle"});
      tick();
      reg_en = 1'b0;
   endtask

   initial begin
      vecs[0] = '{1'b1, 8'h0A, 8'h00, 0, 0, 0, 1'b0, "wr_0a"};
      vecs[1] = '{1'b1, 8'h04, 8'h45, 3, 0, 0, 1'b0, "wr_nxt_late"};
      vecs[2] = '{1'b1, 8'h3F, 8'hFF, 0, 2, 0, 1'b0, "wr_wd_stall"};
      vecs[3] = '{1'b1, 8'hC5, 8'hA5, 1, 1, 0, 1'b1, "wr_hold_en"};
      vecs[4] = '{1'b1, 8'h11, 8'h33, 20, 0, 0, 1'b0, "wr_tmo_tx"};
      vecs[5] = '{1'b1, 8'h22, 8'h44, 0, 20, 0, 1'b0, "wr_tmo_wd"};
      vecs[6] = '{1'b1, 8'h05, 8'h5A, 0, 0, 3, 1'b0, "wr_dir_busy"};
      vecs[7] = '{1'b0, 8'h16, 8'h00, 0, 0, 0, 1'b0, "rd_plain"};
      vecs[8] = '{1'b0, 8'h2B, 8'h00, 0, 0, 2, 1'b1, "rd_dir_busy"};

      // Reset state
      exp_dout = 8'h00;
      expect_out(8'h00, 1'b0, 1'b0, 1'b0, "reset");
      tick();
      rst = 1'b0;
      expect_out(8'h00, 1'b0, 1'b0, 1'b0, "reset_idle");
      tick();

      for (int unsigned i = 0; i < 9; i++) run_vec(vecs[i]);

      // RX cmd preemption during WDATA, then re-issue
      reg_en = 1'b1; reg_we = 1'b1; reg_addr = 8'h04; reg_din = 8'h49; ulpi_dir = 1'b0; ulpi_nxt = 1'b1;
      expect_out(8'h84, 1'b0, 1'b0, 1'b0, "pre_txcmd"); tick();
      reg_en = 1'b0;
      expect_out(8'h49, 1'b0, 1'b0, 1'b0, "pre_wdata"); tick();
      ulpi_dir = 1'b1; ulpi_nxt = 1'b0;
      expect_out(8'h00, 1'b0, 1'b0, 1'b0, "pre_abort"); tick();
      for (int unsigned i = 0; i < 3; i++) begin
         expect_out(8'h00, 1'b0, 1'b0, 1'b0, "pre_wait"); tick();
      end
      ulpi_dir = 1'b0;
      expect_out(8'h84, 1'b0, 1'b0, 1'b0, "pre_resend"); tick();
      ulpi_nxt = 1'b1;
      expect_out(8'h49, 1'b0, 1'b0, 1'b0, "pre_wdata2"); tick();
      expect_out(8'h00, 1'b1, 1'b0, 1'b0, "pre_stp"); tick();
      ulpi_nxt = 1'b0;
      expect_out(8'h00, 1'b0, 1'b1, 1'b0, "pre_done"); tick();
      expect_out(8'h00, 1'b0, 1'b0, 1'b0, "pre_idle"); tick();

      // Reset while in WDATA, then a fresh request
      reg_en = 1'b1; reg_we = 1'b1; reg_addr = 8'h07; reg_din = 8'h11; ulpi_nxt = 1'b1;
      expect_out(8'h87, 1'b0, 1'b0, 1'b0, "rst_txcmd"); tick();
      reg_en = 1'b0;
      expect_out(8'h11, 1'b0, 1'b0, 1'b0, "rst_wdata"); tick();
      rst = 1'b1;
      exp_dout = 8'h00;
      expect_out(8'h00, 1'b0, 1'b0, 1'b0, "rst_mid"); tick();
      rst = 1'b0; ulpi_nxt = 1'b0;
      expect_out(8'h00, 1'b0, 1'b0, 1'b0, "rst_after1"); tick();
      expect_out(8'h00, 1'b0, 1'b0, 1'b0, "rst_after2"); tick();
      run_vec(vecs[0]);

`ifdef ULPI_REG_READ_EN
      // Register read with PHY turnaround
      reg_en = 1'b1; reg_we = 1'b0; reg_addr = 8'h16; ulpi_nxt = 1'b0; ulpi_dir = 1'b0;
      expect_out(8'hD6, 1'b0, 1'b0, 1'b0, "rd_txcmd"); tick();
      reg_en = 1'b0; ulpi_nxt = 1'b1;
      expect_out(8'h00, 1'b0, 1'b0, 1'b0, "rd_rturn"); tick();
      ulpi_nxt = 1'b0; ulpi_dir = 1'b1;
      expect_out(8'h00, 1'b0, 1'b0, 1'b0, "rd_turn"); tick();
      ulpi_data_in = 8'h5A;
      expect_out(8'h00, 1'b0, 1'b0, 1'b0, "rd_data"); tick();
      ulpi_dir = 1'b0; ulpi_data_in = 8'h00;
      exp_dout = 8'h5A;
      expect_out(8'h00, 1'b0, 1'b1, 1'b0, "rd_done"); tick();
      expect_out(8'h00, 1'b0, 1'b0, 1'b0, "rd_idle"); tick();
`endif

      if (sb.size() != 0) begin
         total++;
         bad++;
         $display("FAIL scoreboard_leftover: got %0d pending entries, required 0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/ulpi_reg_ctl.md
ULPI_REG_CTL -- requirements
Module: ulpi_reg_ctl

Interface
REQ-001 SHALL have parameter NXT_TIMEOUT, default 255: max cycles waited per handshake step before abandoning the access.
REQ-002 SHALL have port clk, input, 1: single clock, 60 MHz ULPI clock.
REQ-003 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port reg_en, input, 1: access request strobe, sampled only in IDLE.
REQ-005 SHALL have port reg_we, input, 1: 1 = register write, 0 = register read.
REQ-006 SHALL have port reg_addr, input, 8: register address; bits [5:0] used, [7:6] ignored.
REQ-007 SHALL have port reg_din, input, 8: write data.
REQ-008 SHALL have port reg_rdy, output, 1: one-cycle completion pulse.
REQ-009 SHALL have port reg_dout, output, 8: read data, valid from the reg_rdy cycle until the next completion.
REQ-010 SHALL have port reg_err, output, 1: qualifies reg_rdy; 1 = timeout.
REQ-011 SHALL have port ulpi_dir, input, 1: PHY owns bus when 1.
REQ-012 SHALL have port ulpi_nxt, input, 1: PHY throttle.
REQ-013 SHALL have port ulpi_data_in, input, 8: bus data from PHY.
REQ-014 SHALL have port ulpi_data_out, output, 8: bus data to PHY; 8'h00 when idle.
REQ-015 SHALL have port ulpi_stp, output, 1: stop strobe.

Function
REQ-016 SHALL implement states IDLE, TXCMD, WDATA, STP, RTURN, RDATA, WAITBUS, DONE, with all outputs registered.
REQ-017 In IDLE, reg_en=1 SHALL latch addr, din and we, then go to TXCMD when ulpi_dir=0, else to WAITBUS.
REQ-018 reg_en asserted outside IDLE SHALL be ignored; no queuing.
REQ-019 TXCMD SHALL drive {2'b10,addr[5:0]} for a write and {2'b11,addr[5:0]} for a read.
REQ-020 TXCMD with ulpi_nxt=1 and ulpi_dir=0 SHALL go to WDATA for a write or RTURN for a read.
REQ-021 WDATA SHALL drive din; ulpi_nxt=1 SHALL go to STP.
REQ-022 STP SHALL assert ulpi_stp=1 with data 8'h00 for exactly one cycle, then go to DONE.
REQ-023 RTURN SHALL drive 8'h00 and wait for ulpi_dir=1, then go to RDATA.
REQ-024 RDATA SHALL capture ulpi_data_in into reg_dout on the first cycle after the turnaround cycle, then wait for ulpi_dir=0 and go to DONE.
REQ-025 DONE SHALL pulse reg_rdy for one cycle and return to IDLE.
REQ-026 Write latency with nxt already high SHALL be 4 cycles: request cycle 0, TXCMD 1, WDATA 2, STP 3, reg_rdy 4.
REQ-027 ulpi_dir rising in TXCMD or WDATA (RX cmd preemption) SHALL abort the transfer, drive 8'h00, go to WAITBUS, and not pulse reg_rdy.
REQ-028 WAITBUS SHALL wait for ulpi_dir=0 and then re-issue from TXCMD with the latched request.
REQ-029 A timeout counter SHALL clear on every state change and count in TXCMD, WDATA, RTURN, RDATA and WAITBUS.
REQ-030 Reaching NXT_TIMEOUT SHALL go to STP, then DONE with reg_err=1; reg_dout SHALL be left unchanged on a timeout.
REQ-031 reg_err SHALL be 0 on every non-timeout completion.

Reset
REQ-032 rst SHALL force IDLE, ulpi_stp=0, ulpi_data_out=8'h00, reg_rdy=0, reg_err=0, reg_dout=8'h00, and counter=0.
REQ-033 rst asserted mid-transfer SHALL abandon the access with no reg_rdy pulse and no ulpi_stp pulse.

Configuration
REQ-034 With ULPI_REG_READ_EN defined, reads SHALL follow REQ-019 to REQ-024.
REQ-035 Without ULPI_REG_READ_EN, a read request SHALL cause no bus activity, complete with reg_rdy 1 cycle after the request and reg_err=0, and return reg_dout=8'h00; RTURN and RDATA SHALL be absent.

Verification
REQ-036 Write addr=0x0A din=0x00, nxt tied 1 -> data 0x8A then 0x00, stp at cycle 3, reg_rdy at cycle 4.
REQ-037 Write addr=0x04 din=0x45, nxt low for 3 cycles in TXCMD -> 0x84 held 3 extra cycles, then 0x45, stp, reg_rdy with reg_err=0.
REQ-038 Read addr=0x16, PHY turnaround then returns 0x5A -> TXCMD 0xD6, reg_dout=0x5A at reg_rdy.
REQ-039 Write 0x49 with dir pulsed high for 4 cycles during WDATA -> abort, TXCMD 0x84 re-sent after dir falls, exactly one reg_rdy.
REQ-040 Write with nxt never asserted, NXT_TIMEOUT=8 -> stp after 8 TXCMD cycles, then reg_rdy=1 and reg_err=1.
REQ-041 rst asserted in WDATA -> next cycle data 0x00, stp=0, no reg_rdy; a fresh request then completes normally.
